rgb_pix_asm: RTL



---
 rtl/rgb_pix_asm_if.sv | 24 ++
 rtl/rgb_pix_asm.sv | 116 +++++++++++
 2 files changed

// File: rtl/rgb_pix_asm_if.sv
// Pixel stream from the WS2812b bit assembler to the RGBW converter.
// Valid/ready handshake; the master holds grb/idx stable while valid is high.
interface rgb_pix_asm_if #(
  parameter int IDX_W = 9
);
  logic [23:0]      pix_grb;
  logic [IDX_W-1:0] pix_idx;
  logic             pix_valid;
  logic             pix_ready;

  modport master (
    output pix_grb,
    output pix_idx,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_grb,
    input  pix_idx,
    input  pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/rgb_pix_asm.sv
// Assembles WS2812b decoder bit strobes MSB-first into 24-bit GRB pixels,
// tags each with its frame position and offers it through one holding register.
module rgb_pix_asm #(
  parameter int MAX_LEDS = 256,
  parameter int IDX_W    = $clog2(MAX_LEDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_strobe,
  input  logic              bit_stream_reset,
  rgb_pix_asm_if.master     pix,
  output logic              frame_start,
  output logic              partial_err,
  output logic              overrun,
  output logic [IDX_W-1:0]  frame_pix_cnt
);

  localparam logic [IDX_W-1:0] CNT_MAX  = IDX_W'(MAX_LEDS);
  localparam logic [4:0]       LAST_BIT = 5'd23;

  logic [22:0]      shreg;
  logic [4:0]       bit_cnt;
  logic [23:0]      grb_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] cnt_q;
  logic             valid_q;
  logic             fs_q;
  logic             pe_q;
  logic             ovr_q;

  logic             bit_ev;
  logic             sr_ev;
  logic             word_done;
  logic             accept;
  logic             xfer;
  logic             load;
  logic             drop;
  logic [23:0]      word_next;

  always_comb begin
    bit_ev    = bit_strobe & ~bit_stream_reset;
    sr_ev     = bit_strobe & bit_stream_reset;
    word_done = bit_ev && (bit_cnt == LAST_BIT);
    accept    = word_done && (cnt_q < CNT_MAX);
    xfer      = valid_q & pix.pix_ready;
    // A held pixel leaving this cycle frees the register for a new word.
    load      = accept && (!valid_q || pix.pix_ready);
    drop      = accept && valid_q && !pix.pix_ready;
    word_next = {shreg, bit_in};
  end

  // Bit collection
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (sr_ev) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (bit_ev) begin
      shreg   <= word_next[22:0];
      bit_cnt <= word_done ? '0 : bit_cnt + 5'd1;
    end
  end

  // Frame position counter; saturates so extra LEDs are silently ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (sr_ev) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      grb_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      grb_q   <= word_next;
      idx_q   <= cnt_q;
      valid_q <= 1'b1;
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  // Status pulses and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      fs_q  <= 1'b0;
      pe_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      fs_q <= sr_ev;
      pe_q <= sr_ev && (bit_cnt != '0);
      if (drop) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign pix.pix_grb   = grb_q;
  assign pix.pix_idx   = idx_q;
  assign pix.pix_valid = valid_q;
  assign frame_start   = fs_q;
  assign partial_err   = pe_q;
  assign overrun       = ovr_q;
  assign frame_pix_cnt = cnt_q;

endmodule
